// File: rtl/deser_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// deser_pkg : shared state encoding and bit-position helper for deser_stream
// Revision  : 1.0
// ----------------------------------------------------------------------------
package deser_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Position in the word that the sample at 'count' occupies.
    function automatic int unsigned bit_idx(input int unsigned count,
                                            input int unsigned width,
                                            input bit          lsb_first);
        return lsb_first ? count : (width - 1 - count);
    endfunction

endpackage
`default_nettype wire

// File: rtl/deser_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// deser_if : serial input, control and word-output signals of deser_stream
// Revision : 1.0
// ----------------------------------------------------------------------------
interface deser_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             bit_valid;
    logic             data_in;
    logic             out_ready;
    logic             overrun_clr;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    modport master (
        output start, bit_valid, data_in, out_ready, overrun_clr,
        input  out_data, out_valid, busy, frame_err, overrun
    );

    modport slave (
        input  start, bit_valid, data_in, out_ready, overrun_clr,
        output out_data, out_valid, busy, frame_err, overrun
    );
endinterface
`default_nettype wire

// File: rtl/deser_out_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// deser_out_buf : one-entry output holding register with sticky overrun flag
// Revision      : 1.0
// ----------------------------------------------------------------------------
module deser_out_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             out_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             w_transfer;
    logic             w_accept;

    assign w_transfer = r_valid & out_ready;
    // A slot is free if empty or being drained in this same cycle.
    assign w_accept   = ~r_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (load && w_accept) begin
                r_data  <= word;
                r_valid <= 1'b1;
            end else if (w_transfer) begin
                r_valid <= 1'b0;
            end

            if (load && !w_accept) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: rtl/deser_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// deser_stream : start-qualified, gap-tolerant serial-to-parallel deserializer
// Revision     : 1.0
// ----------------------------------------------------------------------------
module deser_stream
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic    clk,
    input  logic    rst,
    deser_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_mask;
    logic             r_frame_err;
    logic             w_frame_err_nxt;
    logic             w_load;

    assign w_mask = {{(WIDTH-1){1'b0}}, 1'b1} << bit_idx(32'(r_count), WIDTH, LSB_FIRST != 0);

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_shift_nxt     = r_shift;
        w_frame_err_nxt = 1'b0;
        w_load          = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = SHIFT;
                    w_count_nxt = '0;
                end
            end
            SHIFT: begin
                if (bus.start) begin
                    w_count_nxt     = '0;
                    w_shift_nxt     = '0;
                    w_frame_err_nxt = 1'b1;
                end else if (bus.bit_valid) begin
                    w_shift_nxt = (r_shift & ~w_mask) | (bus.data_in ? w_mask : '0);
                    if (r_count == CW'(WIDTH - 1)) begin
                        w_state_nxt = IDLE;
                        w_count_nxt = '0;
                        w_load      = 1'b1;
                    end else begin
                        w_count_nxt = r_count + CW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // The completing bit is folded in combinationally so the word lands in
    // the buffer on the same edge that returns the FSM to IDLE.
    deser_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (w_load),
        .word        (w_shift_nxt),
        .out_ready   (bus.out_ready),
        .overrun_clr (bus.overrun_clr),
        .out_data    (bus.out_data),
        .out_valid   (bus.out_valid),
        .overrun     (bus.overrun)
    );

    assign bus.busy      = (r_state == SHIFT);
    assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_deser_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_deser_stream : directed bench for deser_stream, LSB-first and MSB-first
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_deser_stream;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic bit_valid = 1'b0;
    logic data_in = 1'b0;
    logic out_ready = 1'b1;
    logic overrun_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    deser_if #(.WIDTH(8)) if_l ();
    deser_if #(.WIDTH(8)) if_m ();

    assign if_l.start       = start;
    assign if_l.bit_valid   = bit_valid;
    assign if_l.data_in     = data_in;
    assign if_l.out_ready   = out_ready;
    assign if_l.overrun_clr = overrun_clr;
    assign if_m.start       = start;
    assign if_m.bit_valid   = bit_valid;
    assign if_m.data_in     = data_in;
    assign if_m.out_ready   = out_ready;
    assign if_m.overrun_clr = overrun_clr;

    deser_stream #(.WIDTH(8), .LSB_FIRST(1)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (if_l.slave)
    );

    deser_stream #(.WIDTH(8), .LSB_FIRST(0)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (if_m.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // seq[i] is the i-th bit on the wire.
    task automatic send_frame(input logic [7:0] seq, input int gap);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1;
            data_in   = seq[i];
            tick();
            bit_valid = 1'b0;
            if (i < 7) repeat (gap) tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (if_l.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", if_l.out_data); end
        n_cmp++; if (if_l.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", if_l.out_valid); end
        n_cmp++; if (if_l.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", if_l.busy); end
        n_cmp++; if (if_l.frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", if_l.frame_err); end
        n_cmp++; if (if_l.overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", if_l.overrun); end
    endtask

    task automatic test_basic();
        logic [7:0] seq;
        seq = 8'hA5;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (if_l.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy[%0d]: got %b want 1", i + 1, if_l.busy); end
            n_cmp++; if (if_l.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid[%0d]: got %b want 0", i + 1, if_l.out_valid); end
            bit_valid = 1'b1;
            data_in   = seq[i];
            tick();
        end
        bit_valid = 1'b0;
        n_cmp++; if (if_l.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", if_l.out_valid); end
        n_cmp++; if (if_l.out_data !== 8'hA5) begin n_err++; $display("FAIL basic_data: got %h want a5", if_l.out_data); end
        n_cmp++; if (if_l.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_done: got %b want 0", if_l.busy); end
        tick();
        n_cmp++; if (if_l.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", if_l.out_valid); end
        n_cmp++; if (if_l.out_data !== 8'hA5) begin n_err++; $display("FAIL basic_hold_data: got %h want a5", if_l.out_data); end
    endtask

    task automatic test_bit_order();
        out_ready = 1'b1;
        send_frame(8'h01, 0);
        n_cmp++; if (if_l.out_data !== 8'h01) begin n_err++; $display("FAIL order_lsb: got %h want 01", if_l.out_data); end
        n_cmp++; if (if_m.out_data !== 8'h80) begin n_err++; $display("FAIL order_msb: got %h want 80", if_m.out_data); end
        n_cmp++; if (if_m.out_valid !== 1'b1) begin n_err++; $display("FAIL order_msb_valid: got %b want 1", if_m.out_valid); end
        tick();
        send_frame(8'h01, 3);
        n_cmp++; if (if_l.out_valid !== 1'b1) begin n_err++; $display("FAIL gap_valid: got %b want 1", if_l.out_valid); end
        n_cmp++; if (if_l.out_data !== 8'h01) begin n_err++; $display("FAIL gap_lsb: got %h want 01", if_l.out_data); end
        n_cmp++; if (if_m.out_data !== 8'h80) begin n_err++; $display("FAIL gap_msb: got %h want 80", if_m.out_data); end
        tick();
    endtask

    task automatic test_overrun();
        logic [7:0] seq;
        seq = 8'h34;
        out_ready = 1'b0;
        send_frame(8'h12, 0);
        n_cmp++; if (if_l.out_data !== 8'h12) begin n_err++; $display("FAIL ovr_first: got %h want 12", if_l.out_data); end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit_valid   = 1'b1;
            data_in     = seq[i];
            overrun_clr = (i == 7);
            tick();
        end
        bit_valid   = 1'b0;
        overrun_clr = 1'b0;
        n_cmp++; if (if_l.out_data !== 8'h12) begin n_err++; $display("FAIL ovr_keep: got %h want 12", if_l.out_data); end
        n_cmp++; if (if_l.out_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", if_l.out_valid); end
        n_cmp++; if (if_l.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set_wins: got %b want 1", if_l.overrun); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (if_l.out_valid !== 1'b0) begin n_err++; $display("FAIL ovr_drain: got %b want 0", if_l.out_valid); end
        n_cmp++; if (if_l.out_data !== 8'h12) begin n_err++; $display("FAIL ovr_drain_data: got %h want 12", if_l.out_data); end
        n_cmp++; if (if_l.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", if_l.overrun); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        n_cmp++; if (if_l.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", if_l.overrun); end
    endtask

    task automatic test_same_cycle_transfer();
        logic [7:0] seq;
        seq = 8'h56;
        out_ready = 1'b0;
        send_frame(8'h12, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1;
            data_in   = seq[i];
            out_ready = (i == 7);
            tick();
        end
        bit_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (if_l.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", if_l.out_valid); end
        n_cmp++; if (if_l.out_data !== 8'h56) begin n_err++; $display("FAIL b2b_data: got %h want 56", if_l.out_data); end
        n_cmp++; if (if_l.overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", if_l.overrun); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_restart();
        logic [7:0] seq;
        seq = 8'hC3;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) begin
            bit_valid = 1'b1;
            data_in   = 1'b1;
            tick();
        end
        start     = 1'b1;
        bit_valid = 1'b1;
        data_in   = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
        n_cmp++; if (if_l.frame_err !== 1'b1) begin n_err++; $display("FAIL restart_err: got %b want 1", if_l.frame_err); end
        n_cmp++; if (if_l.busy !== 1'b1) begin n_err++; $display("FAIL restart_busy: got %b want 1", if_l.busy); end
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1;
            data_in   = seq[i];
            tick();
            if (i == 0) begin
                n_cmp++; if (if_l.frame_err !== 1'b0) begin n_err++; $display("FAIL restart_err_width: got %b want 0", if_l.frame_err); end
            end
        end
        bit_valid = 1'b0;
        n_cmp++; if (if_l.out_valid !== 1'b1) begin n_err++; $display("FAIL restart_valid: got %b want 1", if_l.out_valid); end
        n_cmp++; if (if_l.out_data !== 8'hC3) begin n_err++; $display("FAIL restart_lsb: got %h want c3", if_l.out_data); end
        n_cmp++; if (if_m.out_data !== 8'hC3) begin n_err++; $display("FAIL restart_msb: got %h want c3", if_m.out_data); end
        tick();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        send_frame(8'hAA, 0);
        send_frame(8'hBB, 0);
        n_cmp++; if (if_l.overrun !== 1'b1) begin n_err++; $display("FAIL rst_pre_overrun: got %b want 1", if_l.overrun); end
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) begin
            bit_valid = 1'b1;
            data_in   = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (if_l.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", if_l.out_valid); end
        n_cmp++; if (if_l.out_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", if_l.out_data); end
        n_cmp++; if (if_l.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", if_l.busy); end
        n_cmp++; if (if_l.frame_err !== 1'b0) begin n_err++; $display("FAIL rst_frame_err: got %b want 0", if_l.frame_err); end
        n_cmp++; if (if_l.overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b want 0", if_l.overrun); end
        out_ready = 1'b1;
        send_frame(8'hFF, 0);
        n_cmp++; if (if_l.out_valid !== 1'b1) begin n_err++; $display("FAIL rst_next_valid: got %b want 1", if_l.out_valid); end
        n_cmp++; if (if_l.out_data !== 8'hFF) begin n_err++; $display("FAIL rst_next_data: got %h want ff", if_l.out_data); end
        n_cmp++; if (if_l.frame_err !== 1'b0) begin n_err++; $display("FAIL rst_next_err: got %b want 0", if_l.frame_err); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bit_order();
        test_overrun();
        test_same_cycle_transfer();
        test_restart();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/deser_stream.md
Name: deser_stream

Overview:
Parametrised serial-to-parallel deserializer with a start-qualified frame, a per-bit valid qualifier, selectable bit order and a one-entry output buffer with a valid/ready handshake. It sits between a bit-serial source (pin sampler or UART-style front end) and a word-wide consumer. It adds gap-tolerant sampling, frame restart with error reporting, and overrun detection.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
LSB_FIRST, 1, 1 = first received bit lands in bit 0; 0 = first received bit lands in bit WIDTH-1.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  frame start request.
bit_valid  input  1  data_in carries a valid bit this cycle.
data_in  input  1  serial data bit.
out_ready  input  1  consumer accepts out_data this cycle.
overrun_clr  input  1  clears the sticky overrun flag.
out_data  output  WIDTH  assembled word; held stable while out_valid=1.
out_valid  output  1  out_data holds an unconsumed word.
busy  output  1  state is SHIFT.
frame_err  output  1  one-cycle pulse when a partial frame is aborted by start.
overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE; bit count=0; shift register=0.
- Reset values of outputs: out_data=0, out_valid=0, busy=0, frame_err=0, overrun=0.
- rst asserted mid-frame discards the partial frame and any buffered word, with no error pulse.
- States:
  - IDLE: start=1 moves to SHIFT with count=0. Any bit_valid in the same cycle is ignored.
  - SHIFT: each cycle with bit_valid=1 and start=0 samples data_in into bit position idx, then increments count. idx=count when LSB_FIRST=1; idx=WIDTH-1-count otherwise. bit_valid=0 holds all state, so gaps of any length are allowed.
  - Frame completion: a sample with count==WIDTH-1 completes the frame, moves to IDLE and presents the word (see buffer rules).
  - Restart: start=1 in SHIFT takes priority over bit_valid. The partial frame is discarded, count resets to 0, the state stays SHIFT and frame_err=1 for the next cycle only.
- Counter width is $clog2(WIDTH). Count never exceeds WIDTH-1. Unsampled shift-register bits are don't-care, because every bit is overwritten before completion.
- Latency: with start in cycle T and bits in T+1..T+WIDTH, out_valid=1 and out_data are valid in cycle T+WIDTH+1. busy=0 in that cycle.
- Output buffer (one entry):
  - A transfer occurs in a cycle with out_valid=1 and out_ready=1.
  - Completion with the buffer empty, or with a transfer in the same cycle: load the new word and set out_valid=1.
  - Completion with out_valid=1 and no transfer in that cycle: drop the new word, keep the old word, and set overrun=1.
  - Transfer with no completion: out_valid=0 next cycle; out_data keeps its last value.
- overrun stays set until overrun_clr=1. If set and clear happen in the same cycle, set wins.
- A new frame may start while out_valid=1, so shifting overlaps with the wait for the consumer.
- Back-to-back frames: start may be asserted in the cycle after completion.

Decomposition:
- Shared package deser_pkg: state encoding localparams (IDLE=1'b0, SHIFT=1'b1) and a function for the bit-position index given count, WIDTH and LSB_FIRST.
- One sub-module, deser_out_buf: WIDTH-parametrised one-entry holding register. Inputs: load, word, out_ready, overrun_clr. Outputs: out_data, out_valid, overrun.
- The top level holds the FSM, the counter and the shift register.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, out_ready=1: start at cycle 0, stream 1,0,1,0,0,1,0,1 in cycles 1..8 -> out_valid=1 with out_data=0xA5 at cycle 9; busy=1 in cycles 1..8, busy=0 at cycle 9.
2. LSB_FIRST=0 vs 1, stream 1,0,0,0,0,0,0,0 -> out_data=0x80 (LSB_FIRST=0) and 0x01 (LSB_FIRST=1). Repeat with 3-cycle bit_valid=0 gaps between bits -> same words; completion delayed by the total gap length.
3. out_ready=0: frame 0x12, then frame 0x34 completes -> out_data stays 0x12 and overrun=1. Raise out_ready -> 0x12 transferred, out_valid=0. Pulse overrun_clr -> overrun=0.
4. Completion of 0x56 in the same cycle out_ready accepts 0x12 -> no overrun; out_valid stays 1 with out_data=0x56.
5. start in SHIFT after 3 bits -> frame_err pulses for exactly one cycle; the next 8 bits form the full word 0xC3 with no residue from the aborted frame.
6. rst asserted after 5 bits and with out_valid=1 -> all outputs 0 on the next cycle. A subsequent full frame 0xFF is received correctly.
